// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
// Helpers work on a fixed 32-bit container; callers zero-extend narrower pointers
// and truncate the result, which is exact for both conversions.
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
  localparam int unsigned FUNC_W         = 32;

  // Binary to reflected Gray code.
  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary via prefix XOR from the MSB down.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b[FUNC_W-1] = g[FUNC_W-1];
    for (int i = int'(FUNC_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parameterised Gray-to-binary converter (pure combinational XOR prefix).
// Shared by write-side almost-full and read-side level logic.
// Ports:
//   gray  in  W  Gray-coded pointer
//   bin   out W  binary pointer (combinational, _c style path by nature)
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = PTR_WIDTH_DEF
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  assign bin[W-1] = gray[W-1];
  for (genvar i = 0; i < int'(W) - 1; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for the asynchronous FIFO.
// Holds the binary write pointer, drives memory write address/strobe, publishes a
// registered Gray write pointer for the read domain, and registers FULL from the
// already-synchronised Gray read pointer.
// Optional feature macro: FIFO_ALMOST_FULL_EN (adds ALMOST_FULL and level logic).
// Ports:
//   CLK          in   1            write-domain clock
//   RST          in   1            async active-low reset
//   W_INC        in   1            producer write request
//   Rd_ptr_sync  in   ADDR_WIDTH+1 Gray read pointer synchronised into CLK domain
//   W_EN         out  1            memory write strobe (combinational)
//   W_addr       out  ADDR_WIDTH   memory write address (registered)
//   Wr_ptr_gray  out  ADDR_WIDTH+1 registered Gray write pointer
//   FULL         out  1            registered full flag
//   ALMOST_FULL  out  1            registered almost-full flag (macro only)
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned AF_MARGIN  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   Rd_ptr_sync,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_addr,
  output logic [ADDR_WIDTH:0]   Wr_ptr_gray,
`ifdef FIFO_ALMOST_FULL_EN
  output logic                  FULL,
  output logic                  ALMOST_FULL
`else
  output logic                  FULL
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // Elaboration-time parameter sanity.
  if (ADDR_WIDTH < 2) begin : g_bad_aw
    $error("fifo_wptr_full: ADDR_WIDTH must be at least 2");
  end
  if (AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_bad_af
    $error("fifo_wptr_full: AF_MARGIN must be in 1..DEPTH-1");
  end

  logic [PTR_W-1:0] wbin_q,  wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic             full_q,  full_d;
  logic [PTR_W-1:0] rd_full_cmp;
  logic             accept;

  // Write accept, next pointers and full comparison.
  always_comb begin
    accept      = W_INC & ~full_q;
    wbin_d      = wbin_q + PTR_W'(accept);
    wgray_d     = PTR_W'(bin2gray(FUNC_W'(wbin_d)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    rd_full_cmp = {~Rd_ptr_sync[PTR_W-1:PTR_W-2], Rd_ptr_sync[PTR_W-3:0]};
    full_d      = (wgray_d == rd_full_cmp);
  end

  // Pointer and flag registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_d;
  logic             af_q, af_d;

  fifo_gray2bin #(.W(PTR_W)) u_rd_g2b (
    .gray (Rd_ptr_sync),
    .bin  (rbin)
  );

  // Occupancy after this edge; modular subtraction handles pointer wrap.
  always_comb begin
    level_d = wbin_d - rbin;
    af_d    = (level_d >= PTR_W'(DEPTH - AF_MARGIN)) | full_d;
  end

  // Almost-full register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign ALMOST_FULL = af_q;
`endif

  assign W_EN        = accept;
  assign W_addr      = wbin_q[ADDR_WIDTH-1:0];
  assign Wr_ptr_gray = wgray_q;
  assign FULL        = full_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (ADDR_WIDTH=3, AF_MARGIN=1).
module tb_fifo_wptr_full;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = AW + 1;

  logic          clk;
  logic          rst;
  logic          w_inc;
  logic [PW-1:0] rd;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [PW-1:0] wgray;
  logic          full;
  logic          af;

  int checks;
  int errors;

  typedef struct {
    logic          w_inc;
    logic [PW-1:0] rd;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
    logic [PW-1:0] exp_gray;
    logic          exp_full;
    logic          exp_af;
  } vec_t;

  vec_t vecs[$];

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(1)) dut (
    .CLK         (clk),
    .RST         (rst),
    .W_INC       (w_inc),
    .Rd_ptr_sync (rd),
    .W_EN        (w_en),
    .W_addr      (w_addr),
    .Wr_ptr_gray (wgray),
`ifdef FIFO_ALMOST_FULL_EN
    .FULL        (full),
    .ALMOST_FULL (af)
`else
    .FULL        (full)
`endif
  );

`ifndef FIFO_ALMOST_FULL_EN
  assign af = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] tb_gray(input int unsigned v);
    logic [PW-1:0] b;
    b = PW'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wi, input logic [PW-1:0] r, input logic wen,
                     input logic [AW-1:0] a, input logic [PW-1:0] g,
                     input logic f, input logic alf);
    vec_t v;
    v.w_inc = wi; v.rd = r; v.exp_wen = wen; v.exp_addr = a;
    v.exp_gray = g; v.exp_full = f; v.exp_af = alf;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] prev;
    checks = 0;
    errors = 0;

    // Fill: 8 writes, FULL on the 8th edge; ALMOST_FULL from the 7th.
    add(1, 4'b0000, 1, 3'd1, 4'b0001, 0, 0);
    add(1, 4'b0000, 1, 3'd2, 4'b0011, 0, 0);
    add(1, 4'b0000, 1, 3'd3, 4'b0010, 0, 0);
    add(1, 4'b0000, 1, 3'd4, 4'b0110, 0, 0);
    add(1, 4'b0000, 1, 3'd5, 4'b0111, 0, 0);
    add(1, 4'b0000, 1, 3'd6, 4'b0101, 0, 0);
    add(1, 4'b0000, 1, 3'd7, 4'b0100, 0, 1);
    add(1, 4'b0000, 1, 3'd0, 4'b1100, 1, 1);
    // Writes while full are ignored.
    add(1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1);
    add(1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1);
    add(1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1);
    // Drain one entry: FULL clears one edge later.
    add(0, 4'b0001, 0, 3'd0, 4'b1100, 0, 1);
    // One more write fills it again.
    add(1, 4'b0001, 1, 3'd1, 4'b1101, 1, 1);
    // Idle while full.
    add(0, 4'b0001, 0, 3'd1, 4'b1101, 1, 1);

    // Reset asserted with W_INC high: state held at zero, W_EN follows W_INC.
    rst   = 1'b0;
    w_inc = 1'b1;
    rd    = '0;
    #12;
    chk("rst_addr", 32'(w_addr), 32'd0);
    chk("rst_gray", 32'(wgray), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd1);
`ifdef FIFO_ALMOST_FULL_EN
    chk("rst_af", 32'(af), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("rst_hold_gray", 32'(wgray), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven sequence.
    prev = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      w_inc = vecs[i].w_inc;
      rd    = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_wen", i), 32'(w_en), 32'(vecs[i].exp_wen));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_addr", i), 32'(w_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_gray", i), 32'(wgray), 32'(vecs[i].exp_gray));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("v%0d_gstep", i), 32'($countones(wgray ^ prev) <= 1), 32'd1);
`ifdef FIFO_ALMOST_FULL_EN
      chk($sformatf("v%0d_af", i), 32'(af), 32'(vecs[i].exp_af));
`endif
      prev = wgray;
    end

    // Mid-operation reset: outputs clear without a clock edge.
    @(negedge clk);
    w_inc = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_addr", 32'(w_addr), 32'd0);
    chk("mrst_gray", 32'(wgray), 32'd0);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_wen", 32'(w_en), 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("mrst_af", 32'(af), 32'd0);
`endif
    rd = '0;
    @(negedge clk);
    rst = 1'b1;

    // Wrap: 16 writes with the read pointer lagging by two entries.
    prev = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      w_inc = 1'b1;
      rd    = tb_gray((i >= 2) ? (i - 2) % 16 : 0);
      #1;
      chk($sformatf("wrap%0d_wen", i), 32'(w_en), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_gray", i), 32'(wgray), 32'(tb_gray(i % 16)));
      chk($sformatf("wrap%0d_addr", i), 32'(w_addr), 32'(i % 8));
      chk($sformatf("wrap%0d_full", i), 32'(full), 32'd0);
      chk($sformatf("wrap%0d_gstep", i), 32'($countones(wgray ^ prev) == 1), 32'd1);
`ifdef FIFO_ALMOST_FULL_EN
      chk($sformatf("wrap%0d_af", i), 32'(af), 32'd0);
`endif
      prev = wgray;
    end
    chk("wrap_final_gray", 32'(wgray), 32'd0);

    @(negedge clk);
    w_inc = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
